// File: rtl/user_module_project_id.sv
// Programmable 4-state, 2-symbol Turing machine on a 16-cell circular tape, loaded through a nibble port.
// Latency: one step or one load per clock, io_out is registered state only; no backpressure, halt (state 3) freezes the machine.
module user_module_project_id (
   input  logic [7:0] io_in,
   output logic [7:0] io_out
);

   logic            clk;
   logic            rst_n;
   logic            run;
   logic            wr;
   logic [3:0]      data;

   logic [7:0][3:0] tbl;
   logic [15:0]     tape;
   logic [3:0]      head;
   logic [1:0]      state;
   logic [3:0]      ptr;

   logic            sym;
   logic            halted;
   logic [3:0]      e;

   assign clk    = io_in[0];
   assign rst_n  = io_in[1];
   assign run    = io_in[2];
   assign wr     = io_in[3];
   assign data   = io_in[7:4];

   assign sym    = tape[head];
   assign halted = (state == 2'd3);
   assign e      = tbl[{state, sym}];

   assign io_out = {halted, state, sym, head};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tbl   <= '0;
         tape  <= '0;
         head  <= '0;
         state <= '0;
         ptr   <= '0;
      end else if (run) begin
         if (!halted) begin
            tape[head] <= e[3];
            head       <= e[2] ? head + 4'd1 : head - 4'd1;
            state      <= e[1:0];
         end
      end else if (wr) begin
         // pointer 0..7 addresses the table, 8..11 the four tape nibbles
         if (!ptr[3])
            tbl[ptr[2:0]] <= data;
         else
            tape[{ptr[1:0], 2'b00} +: 4] <= data;
         ptr <= (ptr == 4'd11) ? 4'd0 : ptr + 4'd1;
      end
   end

endmodule

// File: tb/tb_user_module_project_id.sv
// Bench for the Turing machine slot: directed scenarios with literal expectations plus a randomized run
// checked every cycle against a behavioural model of the machine.
module tb_user_module_project_id;

   logic       clk = 1'b0;
   logic       clk_en = 1'b0;
   logic       rst_n = 1'b0;
   logic       run = 1'b0;
   logic       wr = 1'b0;
   logic [3:0] data = 4'h0;
   logic [7:0] io_in;
   logic [7:0] io_out;

   int errors = 0;
   int checks = 0;
   bit checking = 1'b0;

   // behavioural model of the machine configuration
   logic [3:0] m_tbl [8];
   bit         m_tape [16];
   int         m_head;
   int         m_state;
   int         m_ptr;

   assign io_in = {data, wr, run, rst_n, clk};

   user_module_project_id dut (
      .io_in  (io_in),
      .io_out (io_out)
   );

   always begin
      #5;
      if (clk_en) clk = ~clk;
   end

   function automatic void model_reset();
      for (int i = 0; i < 8; i++) m_tbl[i] = 4'h0;
      for (int i = 0; i < 16; i++) m_tape[i] = 1'b0;
      m_head  = 0;
      m_state = 0;
      m_ptr   = 0;
   endfunction

   function automatic void model_apply(input logic r, input logic w, input logic [3:0] d);
      logic [3:0] ent;
      if (r) begin
         if (m_state != 3) begin
            ent = m_tbl[m_state * 2 + int'(m_tape[m_head])];
            m_tape[m_head] = ent[3];
            m_head  = (m_head + (ent[2] ? 1 : 15)) % 16;
            m_state = int'(ent[1:0]);
         end
      end else if (w) begin
         if (m_ptr < 8)
            m_tbl[m_ptr] = d;
         else
            for (int i = 0; i < 4; i++) m_tape[4 * (m_ptr - 8) + i] = d[i];
         m_ptr = (m_ptr + 1) % 12;
      end
   endfunction

   function automatic logic [7:0] model_out();
      logic [7:0] o;
      o = 8'(m_head);
      o[4] = m_tape[m_head];
      o[6:5] = 2'(m_state);
      o[7] = (m_state == 3);
      return o;
   endfunction

   always @(negedge clk) begin
      if (checking) begin
         checks++;
         if (io_out !== model_out()) begin
            errors++;
            $display("FAIL model_cmp t=%0t io_out=%h expected=%h", $time, io_out, model_out());
         end
      end
   end

   task automatic check_lit(input string name, input logic [7:0] exp);
      checks++;
      if (io_out !== exp) begin
         errors++;
         $display("FAIL %s io_out=%h expected=%h", name, io_out, exp);
      end
   endtask

   task automatic step(input logic r, input logic w, input logic [3:0] d);
      run  = r;
      wr   = w;
      data = d;
      @(posedge clk);
      model_apply(r, w, d);
      @(negedge clk);
   endtask

   // asynchronous reset pulse entirely inside the low clock phase
   task automatic async_rst();
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_lit("async_rst", 8'h00);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      model_reset();
      #3;
      check_lit("reset_noclk", 8'h00);
      rst_n = 1'b1;
      #1;
      check_lit("reset_release", 8'h00);
      clk_en   = 1'b1;
      checking = 1'b1;
      @(negedge clk);

      // fill right: write 1, move right, stay in state 0
      step(1'b0, 1'b1, 4'b1100);
      repeat (3) step(1'b1, 1'b0, 4'h0);
      check_lit("fill_right", 8'h03);

      // halt and wrap: write 1, move left, go to state 3
      async_rst();
      step(1'b0, 1'b1, 4'b1011);
      step(1'b1, 1'b0, 4'h0);
      check_lit("halt_wrap", 8'hEF);
      repeat (5) step(1'b1, 1'b0, 4'h0);
      check_lit("halt_hold", 8'hEF);

      // tape load
      async_rst();
      repeat (8) step(1'b0, 1'b1, 4'h0);
      step(1'b0, 1'b1, 4'h1);
      repeat (3) step(1'b0, 1'b1, 4'h0);
      check_lit("tape_load", 8'h10);
      step(1'b1, 1'b0, 4'h0);
      check_lit("tape_step", 8'h0F);

      // pointer wrap, then wr during run must not move the pointer
      async_rst();
      repeat (12) step(1'b0, 1'b1, 4'h0);
      step(1'b0, 1'b1, 4'b1100);
      repeat (2) step(1'b1, 1'b1, 4'b0011);
      check_lit("ptr_wrap", 8'h02);
      repeat (7) step(1'b0, 1'b1, 4'h0);
      step(1'b0, 1'b1, 4'h4);
      check_lit("wr_in_run", 8'h12);

      // async reset mid-run wipes the loaded table
      async_rst();
      step(1'b0, 1'b1, 4'b1100);
      repeat (2) step(1'b1, 1'b0, 4'h0);
      check_lit("pre_rst_run", 8'h02);
      async_rst();
      repeat (3) step(1'b1, 1'b0, 4'h0);
      check_lit("post_rst_run", 8'h0D);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 59) == 0)
            async_rst();
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      end

      checking = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
